// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder
//   Edge feeder for an NxN output-stationary systolic array. Each accepted
//   A column / B row is injected on a diagonal: lane r reaches the array edge
//   r cycles after lane 0. The PE enable is sequenced as follows:
//   - clear for one cycle,
//   - stream the k vectors (with a zero bubble in any cycle without a transfer),
//   - flush with 2*N zero cycles,
//   - hold in DONE with the accumulators readable.
//   Optional build macro: FEEDER_STALL_CNT_EN adds o_stall_cnt, which counts
//   STREAM cycles that were ready but had no valid input.
module systolic_skew_feeder #(
  parameter int W  = 16,
  parameter int N  = 4,
  parameter int KW = 8
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  logic [KW-1:0]  i_k,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [N*W-1:0] i_a,
  input  logic [N*W-1:0] i_b,
  output logic [N*W-1:0] o_a,
  output logic [N*W-1:0] o_b,
  output logic           o_en,
  output logic           o_busy,
  output logic           o_done
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]    o_stall_cnt
`endif
);

  localparam int FW = $clog2(2 * N + 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(2 * N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t        state;
  logic [KW-1:0] k_q;
  logic [KW-1:0] cnt_q;
  logic [KW:0]   cnt_nxt;
  logic [FW-1:0] flush_q;
  logic          xfer;
  logic [N*W-1:0] inj_a;
  logic [N*W-1:0] inj_b;

  assign xfer    = o_ready & i_valid;
  // One bit wider than k so that k = 2^KW-1 is compared without wrapping.
  assign cnt_nxt = {1'b0, cnt_q} + {{KW{1'b0}}, 1'b1};

  // Injection point: anything other than an accepted vector becomes zeros.
  assign inj_a = xfer ? i_a : '0;
  assign inj_b = xfer ? i_b : '0;

  // Job sequencer: state, vector and flush counters, and the control outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      flush_q <= '0;
      o_ready <= 1'b0;
      o_en    <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            state  <= S_CLEAR;
            k_q    <= i_k;
            o_en   <= 1'b0;
            o_busy <= 1'b1;
          end
        end
        S_CLEAR: begin
          cnt_q <= '0;
          o_en  <= 1'b1;
          if (k_q == '0) begin
            state   <= S_FLUSH;
            flush_q <= '0;
          end else begin
            state   <= S_STREAM;
            o_ready <= 1'b1;
          end
        end
        S_STREAM: begin
          if (xfer) begin
            cnt_q <= cnt_nxt[KW-1:0];
            if (cnt_nxt == {1'b0, k_q}) begin
              state   <= S_FLUSH;
              flush_q <= '0;
              o_ready <= 1'b0;
            end
          end
        end
        S_FLUSH: begin
          flush_q <= flush_q + 1'b1;
          if (flush_q == FLUSH_LAST) begin
            state  <= S_DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          o_ready <= 1'b0;
          o_en    <= 1'b0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Skew lanes: lane r is a delay line of r+1 registers, so lane r of the vector
  // injected in cycle t reaches the edge in cycle t+1+r. Bubbles and flush
  // zeros use the same path.
  for (genvar r = 0; r < N; r++) begin : g_lane
    logic [W-1:0] a_p [0:r];
    logic [W-1:0] b_p [0:r];

    // Stage p0 captures the injected lane; each further stage delays it one cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        for (int s = 0; s <= r; s++) begin
          a_p[s] <= '0;
          b_p[s] <= '0;
        end
      end else begin
        a_p[0] <= inj_a[r*W +: W];
        b_p[0] <= inj_b[r*W +: W];
        for (int s = 1; s <= r; s++) begin
          a_p[s] <= a_p[s-1];
          b_p[s] <= b_p[s-1];
        end
      end
    end

    // Last stage of lane r drives the array edge.
    assign o_a[r*W +: W] = a_p[r];
    assign o_b[r*W +: W] = b_p[r];
  end

`ifdef FEEDER_STALL_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] stall_q;

  // Stall counter: counts ready-but-not-valid STREAM cycles, restarts on each job.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_q <= '0;
    end else if (state == S_CLEAR) begin
      stall_q <= '0;
    end else if (state == S_STREAM && o_ready && !i_valid) begin
      stall_q <= sat_inc16(stall_q);
    end
  end

  assign o_stall_cnt = stall_q;
`endif

endmodule
